// File: rtl/uart_mem_ctrl_if.sv
// uart_mem_ctrl_if: bundles the uart_rx/uart_tx handshakes, the word-RAM
// port and the status flags of uart_mem_ctrl.
//   master : the sequencer (drives tx_*, mem_we/addr/wdata, recv_done, send_done)
//   slave  : the surroundings (uart_rx, uart_tx, RAM, top-level command)
interface uart_mem_ctrl_if #(
  parameter int AW = 9
) ();
  logic          mem2uart;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          recv_done;
  logic          send_done;

  modport master (
    input  mem2uart, rx_dv, rx_byte, tx_active, tx_done, mem_rdata,
    output tx_dv, tx_byte, mem_we, mem_addr, mem_wdata, recv_done, send_done
  );

  modport slave (
    output mem2uart, rx_dv, rx_byte, tx_active, tx_done, mem_rdata,
    input  tx_dv, tx_byte, mem_we, mem_addr, mem_wdata, recv_done, send_done
  );
endinterface

// File: rtl/uart_mem_ctrl.sv
// uart_mem_ctrl: sequencer between uart_rx, uart_tx and a single-port RAM of
// 32-bit words. Received bytes are packed little-endian into words and
// written to RAM; after mem2uart the RAM is read back and streamed byte by
// byte to uart_tx with a full tx_dv / tx_done handshake.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : uart_mem_ctrl_if.master (rx strobe/byte, tx strobe/byte/busy/done,
//          RAM we/addr/wdata/rdata, mem2uart command, recv_done/send_done)
module uart_mem_ctrl #(
  parameter int RX_BYTES = 4096,
  parameter int TX_BYTES = 2048,
  parameter int MEM_SIZE = 512,
  parameter int AW       = 9
) (
  input  logic            clk,
  input  logic            rst,
  uart_mem_ctrl_if.master bus
);

  localparam logic [15:0] RX_LAST = 16'(RX_BYTES);
  localparam logic [15:0] TX_LAST = 16'(TX_BYTES);
  localparam logic [16:0] CAP     = 17'(MEM_SIZE * 4);

  typedef enum logic [2:0] {
    S_RECV, S_WAIT_CMD, S_RD_REQ, S_RD_WAIT, S_TX_LOAD, S_TX_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d;
  logic [31:0]   pack_q, pack_d;
  logic [31:0]   sreg_q, sreg_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          recv_done_q, recv_done_d;
  logic          send_done_q, send_done_d;

  logic [15:0]   rx_cnt_inc, tx_cnt_inc;
  logic [1:0]    lane;
  logic [31:0]   packed_word;
  logic          in_cap;

  always_comb begin
    rx_cnt_inc  = rx_cnt_q + 16'd1;
    tx_cnt_inc  = tx_cnt_q + 16'd1;
    lane        = rx_cnt_q[1:0];
    in_cap      = {1'b0, rx_cnt_q} < CAP;
    // Lane 0 starts a fresh word, so upper lanes are zero until filled; this
    // also provides the zero padding of a trailing partial word.
    packed_word = ((lane == 2'd0) ? 32'h0 : pack_q)
                | (32'(bus.rx_byte) << {lane, 3'b000});

    state_d     = state_q;
    rx_cnt_d    = rx_cnt_q;
    tx_cnt_d    = tx_cnt_q;
    pack_d      = pack_q;
    sreg_d      = sreg_q;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    recv_done_d = recv_done_q;
    send_done_d = send_done_q;

    case (state_q)
      S_RECV: begin
        if (bus.rx_dv) begin
          rx_cnt_d = rx_cnt_inc;
          pack_d   = packed_word;
          // Bytes past RAM capacity are counted but never written.
          if (in_cap && (lane == 2'd3 || rx_cnt_inc == RX_LAST)) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = rx_cnt_q[AW+1:2];
            mem_wdata_d = packed_word;
          end
          if (rx_cnt_inc == RX_LAST) begin
            state_d     = S_WAIT_CMD;
            recv_done_d = 1'b1;
          end
        end
      end
      S_WAIT_CMD: begin
        if (bus.mem2uart) begin
          state_d    = S_RD_REQ;
          mem_addr_d = tx_cnt_q[AW+1:2];
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        sreg_d  = bus.mem_rdata;
        state_d = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        if (!bus.tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = sreg_q[7:0];
          state_d   = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (bus.tx_done) begin
          tx_cnt_d = tx_cnt_inc;
          sreg_d   = {8'h00, sreg_q[31:8]};
          if (tx_cnt_inc == TX_LAST) begin
            state_d     = S_DONE;
            send_done_d = 1'b1;
          end else if (tx_cnt_inc[1:0] == 2'd0) begin
            state_d    = S_RD_REQ;
            mem_addr_d = tx_cnt_inc[AW+1:2];
          end else begin
            state_d = S_TX_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RECV;
      rx_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      recv_done_q <= 1'b0;
      send_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      recv_done_q <= recv_done_d;
      send_done_q <= send_done_d;
    end
  end

  // Byte packer and transmit shift register carry data only.
  always_ff @(posedge clk) begin
    pack_q <= pack_d;
    sreg_q <= sreg_d;
  end

  assign bus.tx_dv     = tx_dv_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.recv_done = recv_done_q;
  assign bus.send_done = send_done_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb_uart_mem_ctrl: randomized self-checking bench for uart_mem_ctrl with a
// behavioural RAM, a simple uart_tx handshake model and a byte-array model
// of the expected RAM contents and transmit stream.
module tb_uart_mem_ctrl;
  localparam int RX_BYTES = 4096;
  localparam int TX_BYTES = 2048;
  localparam int MEM_SIZE = 512;
  localparam int AW       = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_mem_ctrl_if #(.AW(AW)) bus ();

  uart_mem_ctrl #(
    .RX_BYTES(RX_BYTES), .TX_BYTES(TX_BYTES), .MEM_SIZE(MEM_SIZE), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural single-port RAM, one-cycle read latency.
  logic [31:0] ram [MEM_SIZE];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Write / early-transmit logger.
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  int            early_tx = 0;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (bus.tx_dv === 1'b1 && bus.recv_done !== 1'b1) early_tx++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] rx_mem [RX_BYTES];
  bit first_tx_seen = 0;

  task automatic send_rx(input logic [7:0] b, input int gap);
    @(negedge clk);
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    @(negedge clk);
    bus.rx_dv   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.mem2uart = 0; bus.rx_dv = 0; bus.rx_byte = 0;
    bus.tx_active = 0; bus.tx_done = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.tx_dv, bus.mem_we, bus.recv_done, bus.send_done} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000",
               {bus.tx_dv, bus.mem_we, bus.recv_done, bus.send_done});
    else n_pass++;
    n_checks++;
    if ({bus.tx_byte, bus.mem_addr, bus.mem_wdata} !== '0)
      $display("FAIL reset_data: tx_byte=%h addr=%h wdata=%h expected zeros",
               bus.tx_byte, bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_recv();
    for (int i = 0; i < 10; i++) send_rx(8'($urandom), $urandom_range(0, 1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.mem_we, bus.recv_done, bus.tx_dv} !== 3'b000)
      $display("FAIL midrecv_reset_async: got %b expected 000",
               {bus.mem_we, bus.recv_done, bus.tx_dv});
    else n_pass++;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send_rx(8'h11, 1); send_rx(8'h22, 0); send_rx(8'h33, 1); send_rx(8'h44, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 1)
      $display("FAIL midrecv_write_count: got %0d expected 1", wr_addr_q.size());
    else n_pass++;
    if (wr_addr_q.size() >= 1) begin
      n_checks++;
      if ({wr_addr_q[0], wr_data_q[0]} !== {9'd0, 32'h44332211})
        $display("FAIL midrecv_write: addr=%0d data=%h expected addr=0 data=44332211",
                 wr_addr_q[0], wr_data_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_full_recv_early_cmd();
    int early0;
    int c;
    logic [31:0] exp_w;
    pulse_reset();
    early0 = early_tx;
    rx_mem[0] = 8'hAA; rx_mem[1] = 8'hBB; rx_mem[2] = 8'hCC; rx_mem[3] = 8'hDD;
    for (int i = 4; i < RX_BYTES; i++) rx_mem[i] = 8'($urandom);
    for (int i = 0; i < RX_BYTES; i++) begin
      if (i == 1000) bus.mem2uart = 1'b1;
      if (i == 2100) begin
        n_checks++;
        if (wr_addr_q.size() != MEM_SIZE)
          $display("FAIL capacity_writes: got %0d expected %0d", wr_addr_q.size(), MEM_SIZE);
        else n_pass++;
      end
      if (i == RX_BYTES - 1) begin
        n_checks++;
        if (bus.recv_done !== 1'b0)
          $display("FAIL recv_done_early: got %b expected 0", bus.recv_done);
        else n_pass++;
      end
      send_rx(rx_mem[i], (i == RX_BYTES - 1) ? 0 : $urandom_range(0, 1));
    end
    n_checks++;
    if (bus.recv_done !== 1'b1)
      $display("FAIL recv_done_rise: got %b expected 1", bus.recv_done);
    else n_pass++;
    c = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.tx_dv === 1'b1) begin c = k; break; end
    end
    n_checks++;
    if (c != 4) $display("FAIL first_tx_latency: got %0d cycles expected 4", c);
    else n_pass++;
    first_tx_seen = (c != 0);
    n_checks++;
    if (early_tx != early0)
      $display("FAIL tx_before_recv_done: got %0d strobes expected 0", early_tx - early0);
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() != MEM_SIZE)
      $display("FAIL total_writes: got %0d expected %0d", wr_addr_q.size(), MEM_SIZE);
    else n_pass++;
    for (int w = 0; w < MEM_SIZE && w < wr_addr_q.size(); w++) begin
      exp_w = {rx_mem[4*w+3], rx_mem[4*w+2], rx_mem[4*w+1], rx_mem[4*w]};
      n_checks++;
      if ({wr_addr_q[w], wr_data_q[w]} !== {AW'(w), exp_w})
        $display("FAIL word_write[%0d]: addr=%0d data=%h expected addr=%0d data=%h",
                 w, wr_addr_q[w], wr_data_q[w], w, exp_w);
      else n_pass++;
    end
  endtask

  task automatic test_send();
    int c, exp_c, hold, busy_dv;
    for (int i = 0; i < TX_BYTES; i++) begin
      if (i > 0 || !first_tx_seen) begin
        exp_c = (i % 4 == 0) ? 3 : 1;
        c = 0;
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          if (bus.tx_dv === 1'b1) begin c = k; break; end
        end
        n_checks++;
        if (c != exp_c) $display("FAIL tx_latency[%0d]: got %0d expected %0d", i, c, exp_c);
        else n_pass++;
        if (c == 0) begin
          $display("FAIL tx_stall: no tx_dv for byte %0d", i);
          $fatal(1, "send phase stalled");
        end
      end
      n_checks++;
      if (bus.tx_byte !== rx_mem[i])
        $display("FAIL tx_byte[%0d]: got %h expected %h", i, bus.tx_byte, rx_mem[i]);
      else n_pass++;
      bus.tx_active = 1'b1;
      hold = $urandom_range(1, 4);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (k == 0) begin
          n_checks++;
          if (bus.tx_dv !== 1'b0) $display("FAIL tx_dv_width[%0d]: got %b expected 0", i, bus.tx_dv);
          else n_pass++;
        end
        bus.rx_dv   = 1'($urandom_range(0, 1));
        bus.rx_byte = 8'($urandom);
      end
      @(negedge clk);
      bus.rx_dv     = 1'b0;
      bus.tx_done   = 1'b1;
      bus.tx_active = (i == 5);
      @(negedge clk);
      bus.tx_done = 1'b0;
      n_checks++;
      if (bus.send_done !== (i == TX_BYTES - 1))
        $display("FAIL send_done[%0d]: got %b expected %b", i, bus.send_done, (i == TX_BYTES - 1));
      else n_pass++;
      if (i == 5) begin
        busy_dv = 0;
        repeat (50) begin
          @(negedge clk);
          if (bus.tx_dv === 1'b1) busy_dv++;
        end
        n_checks++;
        if (busy_dv != 0) $display("FAIL tx_while_busy: got %0d strobes expected 0", busy_dv);
        else n_pass++;
        bus.tx_active = 1'b0;
      end
    end
    n_checks++;
    if (wr_addr_q.size() != MEM_SIZE)
      $display("FAIL writes_after_recv: got %0d expected %0d", wr_addr_q.size(), MEM_SIZE);
    else n_pass++;
    n_checks++;
    if (bus.recv_done !== 1'b1) $display("FAIL recv_done_sticky: got %b expected 1", bus.recv_done);
    else n_pass++;
  endtask

  task automatic test_done_idle();
    int dv = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.mem2uart = 1'($urandom_range(0, 1));
      bus.rx_dv    = 1'($urandom_range(0, 1));
      bus.rx_byte  = 8'($urandom);
      if (bus.tx_dv === 1'b1) dv++;
    end
    @(negedge clk);
    bus.rx_dv = 1'b0;
    bus.mem2uart = 1'b0;
    n_checks++;
    if (dv != 0 || wr_addr_q.size() != MEM_SIZE)
      $display("FAIL done_idle: tx_dv=%0d writes=%0d expected 0 and %0d", dv, wr_addr_q.size(), MEM_SIZE);
    else n_pass++;
    n_checks++;
    if ({bus.recv_done, bus.send_done} !== 2'b11)
      $display("FAIL done_flags: got %b expected 11", {bus.recv_done, bus.send_done});
    else n_pass++;
  endtask

  task automatic test_reset_after_done();
    logic [31:0] w;
    w = $urandom;
    pulse_reset();
    n_checks++;
    if ({bus.recv_done, bus.send_done, bus.tx_dv, bus.mem_we} !== 4'b0000)
      $display("FAIL reset_after_done: got %b expected 0000",
               {bus.recv_done, bus.send_done, bus.tx_dv, bus.mem_we});
    else n_pass++;
    for (int b = 0; b < 4; b++) send_rx(w[8*b +: 8], $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== w || wr_addr_q[0] !== '0)
      $display("FAIL restart_write: count=%0d data=%h expected 1 write of %h at 0",
               wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, w);
    else n_pass++;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_mid_recv();
    test_full_recv_early_cmd();
    test_send();
    test_done_idle();
    test_reset_after_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
